uart_rx_fifo: RTL and testbench

Byte buffer that sits directly downstream of the UART receiver. It captures each received byte on the rising edge of the receiver's done strobe and holds it in a circular FIFO. A first-word-fall-through valid/ready port presents bytes to the consumer (CPU register interface or packet parser). Bytes that arrive while the FIFO is full are dropped and recorded as overflow.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_fifo_if.sv | 11 +
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_rx_fifo.sv | 81 ++++++++
 tb/tb_uart_rx_fifo.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and their byte buffers.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream from the RX FIFO to its consumer.
interface uart_rx_fifo_if import uart_pkg::*;;

  uart_byte_t m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one combinational read port.
module uart_fifo_mem import uart_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  uart_byte_t        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output uart_byte_t        rd_data
);

  uart_byte_t mem [DEPTH];

  // Storage is intentionally not reset; validity is tracked by the owner's pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures a byte on each rx_done rising edge and presents it FWFT.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  uart_byte_t        rx_data,
  input  logic              rx_done,
  uart_rx_fifo_if.master    m_if,
  input  logic              flush,
  input  logic              clear_ovf,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] PTR_INC = {{ADDR_W{1'b0}}, 1'b1};

  logic            rx_done_q;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            wr_req;
  logic            rd_en;
  logic            wr_en;
  logic            drop;
  uart_byte_t      rd_data;

  assign wr_req = rx_done & ~rx_done_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign m_if.m_valid = ~empty;
  assign m_if.m_data  = empty ? '0 : rd_data;

  // A pop frees a slot in the same edge, so a full FIFO can still accept a byte.
  assign rd_en = m_if.m_valid & m_if.m_ready;
  assign wr_en = wr_req & (~full | rd_en) & ~flush & rst_n;
  assign drop  = wr_req & full & ~rd_en;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      // Edge detector keeps tracking through flush so a held strobe is not re-counted.
      rx_done_q <= rx_done;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_INC;
        if (rd_en) rd_ptr <= rd_ptr + PTR_INC;
        if (drop)
          overflow <= 1'b1;
        else if (clear_ovf)
          overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios followed by random traffic.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  uart_byte_t rx_data;
  logic       rx_done;
  logic       flush;
  logic       clear_ovf;
  logic [4:0] count;
  logic       full, empty, overflow;

  uart_rx_fifo_if m_if ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .m_if      (m_if.master),
    .flush     (flush),
    .clear_ovf (clear_ovf),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain occupancy count, sticky flag and previous strobe level.
  uart_byte_t exp_q[$];
  int         mdl_cnt  = 0;
  bit         mdl_ovf  = 0;
  bit         mdl_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted byte must be the oldest byte the model expects.
  always @(negedge clk) begin
    if (m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=none t=%0t", m_if.m_data, $time);
      end else begin
        chk("pop_data", {24'h0, m_if.m_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_state();
    chk("count", {27'h0, count}, mdl_cnt);
    chk("full", {31'h0, full}, {31'h0, mdl_cnt == DEPTH});
    chk("empty", {31'h0, empty}, {31'h0, mdl_cnt == 0});
    chk("m_valid", {31'h0, m_if.m_valid}, {31'h0, mdl_cnt != 0});
    chk("overflow", {31'h0, overflow}, {31'h0, mdl_ovf});
    if (mdl_cnt == 0)
      chk("m_data_empty", {24'h0, m_if.m_data}, 32'h0);
    else if (exp_q.size() != 0)
      chk("m_data_head", {24'h0, m_if.m_data}, {24'h0, exp_q[0]});
  endtask

  task automatic step(input logic d, input uart_byte_t data, input logic rdy,
                      input logic fl, input logic co, input logic rn);
    bit wr_req, pop, was_full;
    rx_done   = d;
    rx_data   = data;
    m_if.m_ready = rdy;
    flush     = fl;
    clear_ovf = co;
    rst_n     = rn;
    @(posedge clk);
    wr_req   = d && !mdl_prev;
    was_full = (mdl_cnt == DEPTH);
    pop      = (mdl_cnt != 0) && rdy;
    if (!rn) begin
      mdl_cnt = 0; mdl_ovf = 0; mdl_prev = 0;
      exp_q.delete();
    end else begin
      mdl_prev = d;
      if (fl) begin
        mdl_cnt = 0; mdl_ovf = 0;
        exp_q.delete();
      end else begin
        if (pop) mdl_cnt--;
        if (wr_req && (!was_full || pop)) begin
          mdl_cnt++;
          exp_q.push_back(data);
        end
        if (wr_req && was_full && !pop) mdl_ovf = 1;
        else if (co) mdl_ovf = 0;
      end
    end
    #1;
    check_state();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, rdy, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic write_byte(input uart_byte_t b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
  endtask

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_data = '0;
    flush = 1'b0; clear_ovf = 1'b0; m_if.m_ready = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single byte: visible next cycle, gone after one pop.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_data", {24'h0, m_if.m_data}, 32'hA5);
    chk("a5_count", {27'h0, count}, 32'd1);
    idle(1'b1);
    chk("a5_popped_empty", {31'h0, empty}, 32'd1);

    // Stretched strobe writes once.
    for (int i = 0; i < 10; i++) step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stretch_count", {27'h0, count}, 32'd1);
    idle(1'b1);

    // Fill, overflow drop, drain in order.
    for (int i = 0; i < DEPTH; i++) write_byte(uart_byte_t'(i));
    chk("fill_full", {31'h0, full}, 32'd1);
    write_byte(8'h10);
    chk("drop_ovf", {31'h0, overflow}, 32'd1);
    chk("drop_count", {27'h0, count}, 32'd16);
    drain();

    // Full with coincident pop and push, then pointer wrap traffic.
    for (int i = 0; i < DEPTH; i++) write_byte(uart_byte_t'(8'h40 + i));
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pushpop_full_count", {27'h0, count}, 32'd16);
    for (int i = 0; i < 40; i++)
      step(i[0] ? 1'b0 : 1'b1, uart_byte_t'(8'h80 + i), 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // clear_ovf alone clears; a coincident drop wins.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clear_ovf", {31'h0, overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) write_byte(uart_byte_t'(8'hC0 + i));
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clear_vs_drop", {31'h0, overflow}, 32'd1);
    idle(1'b0);

    // Flush beats coincident write and pop.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) write_byte(uart_byte_t'(8'h20 + i));
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_count", {27'h0, count}, 32'd0);
    chk("flush_ovf", {31'h0, overflow}, 32'd0);
    idle(1'b0);

    // Mid-stream reset with bytes buffered.
    for (int i = 0; i < 3; i++) write_byte(uart_byte_t'(8'h50 + i));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_count", {27'h0, count}, 32'd0);
    chk("reset_data", {24'h0, m_if.m_data}, 32'h0);
    // Strobe high on first cycle after release counts as an edge.
    step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_reset_write", {27'h0, count}, 32'd1);
    idle(1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic d, rdy, fl, co;
      d   = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 199) == 0);
      co  = ($urandom_range(0, 29) == 0);
      step(d, uart_byte_t'($urandom_range(0, 255)), rdy, fl, co, 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
